// File: rtl/fourier_rns_seq.sv
`default_nettype none
// ============================================================================
// Module   : fourier_rns_seq
// Brief    : Load / compute / readback sequencer for one fourier_rns engine.
//            Optional compute watchdog enabled by FOURIER_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module fourier_rns_seq #(
   parameter int N       = 100,
   parameter int TIMEOUT = 131072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_re,
   output logic [31:0] out_im,
   output logic        out_last,
   output logic        busy,
   output logic        error,
   output logic        eng_reset,
   output logic [31:0] eng_addr,
   output logic [31:0] eng_x_rns,
   output logic [1:0]  eng_op,
   input  logic [31:0] eng_y_re,
   input  logic [31:0] eng_y_im,
   input  logic        eng_done
);

   if (N < 2 || TIMEOUT < 1) begin : g_bad_params
      $error("fourier_rns_seq: N must be >= 2 and TIMEOUT must be >= 1");
   end

   localparam int            KW     = $clog2(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_RD_REQ  = 3'd4;
   localparam logic [2:0] S_RD_HOLD = 3'd5;

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_COMPUTE = 2'b10;
   localparam logic [1:0] OP_LATCH   = 2'b11;

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          timeout_hit;

`ifdef FOURIER_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] tcnt_q, tcnt_d;
   logic          error_q, error_d;

   // Counter is zero on the first COMPUTE cycle, so TIMEOUT cycles elapse before the abort.
   assign timeout_hit = (state_q == S_COMPUTE) && !eng_done && (tcnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      tcnt_d  = (state_q == S_COMPUTE) ? tcnt_q + 1'b1 : '0;
      error_d = error_q | timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q  <= '0;
         error_q <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_LOAD;
            k_d     = '0;
         end
         S_LOAD: begin
            if (in_valid) begin
               if (k_q == K_LAST) begin
                  state_d = S_COMPUTE;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (eng_done) begin
               state_d = S_RD_REQ;
               k_d     = '0;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
               k_d     = '0;
            end
         end
         S_RD_REQ: begin
            state_d = S_RD_HOLD;
         end
         S_RD_HOLD: begin
            if (out_ready) begin
               if (k_q == K_LAST) begin
                  state_d = S_IDLE;
                  k_d     = '0;
               end else begin
                  state_d = S_RD_REQ;
                  k_d     = k_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // Handshakes are masked while reset is high so nothing is written or emitted
   // during the cycle that is about to be aborted.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = (state_q != S_IDLE);
      eng_reset = reset;
      eng_op    = OP_NOP;
      eng_addr  = 32'(k_q);
      eng_x_rns = '0;
      case (state_q)
         S_CLEAR: begin
            eng_reset = 1'b1;
         end
         S_LOAD: begin
            in_ready  = !reset;
            eng_x_rns = in_data;
            if (in_valid && !reset) begin
               eng_op = OP_WRITE;
            end
         end
         S_COMPUTE: begin
            eng_op = OP_COMPUTE;
         end
         S_RD_REQ: begin
            eng_op = OP_LATCH;
         end
         S_RD_HOLD: begin
            out_valid = !reset;
            out_last  = !reset && (k_q == K_LAST);
         end
         default: begin
            eng_op = OP_NOP;
         end
      endcase
   end

   assign out_re = eng_y_re;
   assign out_im = eng_y_im;

endmodule
`default_nettype wire
